// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the streaming SDF FFT stages.
// Twiddles are built from fixed-point Taylor series so no real math is needed.
package fft_pkg;

  // Wide container for butterfly intermediates; stages support WIDTH up to 31.
  localparam int CPLX_MAX_W = 32;

  typedef struct packed {
    logic signed [CPLX_MAX_W-1:0] re;
    logic signed [CPLX_MAX_W-1:0] im;
  } cplx_t;

  localparam longint Q_ONE = 64'sd1073741824;  // 1.0 in Q30
  localparam longint PI_Q  = 64'sd3373259426;  // pi in Q30

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // sin or cos of x (Q30, 0..pi/2); intermediates stay below 2^63 in that range
  function automatic longint taylor_q(input longint x, input bit do_sin);
    longint x2;
    longint term;
    longint acc;
    longint d;
    x2   = (x * x) >>> 30;
    term = do_sin ? x : Q_ONE;
    acc  = term;
    for (int n = 1; n <= 12; n++) begin
      d    = do_sin ? longint'((2 * n) * (2 * n + 1)) : longint'((2 * n - 1) * (2 * n));
      term = -((term * x2) >>> 30) / d;
      acc  = acc + term;
    end
    return acc;
  endfunction

  // Exponent k must lie in 0..N/2-1, which every SDF stage guarantees.
  function automatic longint tw_comp(input int k, input int log2n, input bit do_sin);
    longint n;
    longint e;
    longint v;
    bit     neg;
    n   = longint'(1) << log2n;
    e   = longint'(k) % n;
    neg = 1'b0;
    if (4 * e > n) begin
      e   = n / 2 - e;
      neg = !do_sin;
    end
    v = taylor_q((2 * PI_Q * e) / n, do_sin);
    return neg ? -v : v;
  endfunction

  function automatic int tw_quant(input longint v, input int tw_width);
    longint mag;
    longint r;
    longint lim;
    mag = (v < 0) ? -v : v;
    lim = (longint'(1) << (tw_width - 1)) - 1;
    r   = ((mag << (tw_width - 1)) + (longint'(1) << 29)) >>> 30;
    if (r > lim) r = lim;
    return int'((v < 0) ? -r : r);
  endfunction

  // W^k = cos(2*pi*k/N) - j*sin(2*pi*k/N), Q1.(tw_width-1)
  function automatic int tw_re(input int k, input int log2n, input int tw_width);
    return tw_quant(tw_comp(k, log2n, 1'b0), tw_width);
  endfunction

  function automatic int tw_im(input int k, input int log2n, input int tw_width);
    return -tw_quant(tw_comp(k, log2n, 1'b1), tw_width);
  endfunction

endpackage

// File: rtl/fft_cmul.sv
// Combinational complex multiply by a Q1.(TW_WIDTH-1) twiddle with
// round-half-up, arithmetic rescale and saturation back to WIDTH.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16
) (
  input  logic signed [WIDTH-1:0]    a_re,
  input  logic signed [WIDTH-1:0]    a_im,
  input  logic signed [TW_WIDTH-1:0] w_re,
  input  logic signed [TW_WIDTH-1:0] w_im,
  output logic signed [WIDTH-1:0]    p_re,
  output logic signed [WIDTH-1:0]    p_im
);

  // Two guard bits cover the product sum and the rounding constant.
  localparam int PW = WIDTH + TW_WIDTH + 2;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_WIDTH - 2);

  logic signed [PW-1:0] ar, ai, wr, wi;
  logic signed [PW-1:0] acc_re, acc_im;
  logic signed [PW-1:0] sh_re, sh_im;

  always_comb begin
    ar     = PW'(a_re);
    ai     = PW'(a_im);
    wr     = PW'(w_re);
    wi     = PW'(w_im);
    acc_re = ar * wr - ai * wi + RND;
    acc_im = ar * wi + ai * wr + RND;
    sh_re  = acc_re >>> (TW_WIDTH - 1);
    sh_im  = acc_im >>> (TW_WIDTH - 1);
    p_re   = WIDTH'(sat(64'(sh_re), WIDTH));
    p_im   = WIDTH'(sat(64'(sh_im), WIDTH));
  end

endmodule

// File: rtl/fft_sdf_stage.sv
// One radix-2 DIF single-path delay-feedback stage. Chain LOG2N of these with
// STAGE = 0..LOG2N-1 for a full streaming N-point FFT.
module fft_sdf_stage
  import fft_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LOG2N    = 3,
  parameter int STAGE    = 0,
  parameter int TW_WIDTH = 16,
  parameter int SCALE    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sync,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    out_valid,
  output logic                    out_sync,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  localparam int D     = 2 ** (LOG2N - 1 - STAGE);
  localparam int CW    = LOG2N - STAGE;
  localparam int AW    = (CW > 1) ? CW - 1 : 1;
  localparam int DEPTH = 2 ** AW;

  logic [CW-1:0]           cnt_reg, cnt_eff;
  logic                    primed_reg, armed_reg;
  logic                    phase_b, emit;
  logic [AW-1:0]           k;
  logic [2*WIDTH-1:0]      dly_mem [DEPTH];
  logic signed [TW_WIDTH-1:0] tw_re_rom [DEPTH];
  logic signed [TW_WIDTH-1:0] tw_im_rom [DEPTH];
  logic signed [WIDTH-1:0] head_re, head_im, rot_re, rot_im;
  logic signed [WIDTH-1:0] sum_re, sum_im, diff_re, diff_im;
  logic signed [WIDTH-1:0] res_re, res_im;
  cplx_t                   head_x, in_x, bf_sum, bf_diff;

  // Twiddle table is fully resolved at elaboration; stage exponent is k*2^STAGE.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tw
      localparam int E   = (gi % D) * (2 ** STAGE);
      localparam int TRE = tw_re(E, LOG2N, TW_WIDTH);
      localparam int TIM = tw_im(E, LOG2N, TW_WIDTH);
      assign tw_re_rom[gi] = TW_WIDTH'(TRE);
      assign tw_im_rom[gi] = TW_WIDTH'(TIM);
    end
  endgenerate

  function automatic logic signed [WIDTH-1:0] bf_scale(input logic signed [CPLX_MAX_W-1:0] v);
    if (SCALE != 0) return WIDTH'(v >>> 1);
    return WIDTH'(sat(64'(v), WIDTH));
  endfunction

  fft_cmul #(
    .WIDTH    (WIDTH),
    .TW_WIDTH (TW_WIDTH)
  ) u_cmul (
    .a_re (head_re),
    .a_im (head_im),
    .w_re (tw_re_rom[k]),
    .w_im (tw_im_rom[k]),
    .p_re (rot_re),
    .p_im (rot_im)
  );

  // A sync sample is treated as count 0 regardless of where the counter was.
  always_comb begin
    cnt_eff            = in_sync ? '0 : cnt_reg;
    phase_b            = cnt_eff[CW-1];
    k                  = AW'(cnt_eff & CW'(D - 1));
    {head_re, head_im} = dly_mem[k];
    head_x.re          = CPLX_MAX_W'(head_re);
    head_x.im          = CPLX_MAX_W'(head_im);
    in_x.re            = CPLX_MAX_W'(in_re);
    in_x.im            = CPLX_MAX_W'(in_im);
    bf_sum.re          = head_x.re + in_x.re;
    bf_sum.im          = head_x.im + in_x.im;
    bf_diff.re         = head_x.re - in_x.re;
    bf_diff.im         = head_x.im - in_x.im;
    sum_re             = bf_scale(bf_sum.re);
    sum_im             = bf_scale(bf_sum.im);
    diff_re            = bf_scale(bf_diff.re);
    diff_im            = bf_scale(bf_diff.im);
    res_re             = phase_b ? sum_re : ((k == '0) ? head_re : rot_re);
    res_im             = phase_b ? sum_im : ((k == '0) ? head_im : rot_im);
    emit               = !in_sync && (primed_reg || (phase_b && armed_reg));
  end

  // Head and tail share address k: an entry written now is read D advances later.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dly_mem[k] <= phase_b ? {diff_re, diff_im} : {in_re, in_im};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      primed_reg <= 1'b0;
      armed_reg  <= 1'b0;
      out_valid  <= 1'b0;
      out_sync   <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
    end else begin
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      if (in_valid) begin
        cnt_reg <= cnt_eff + CW'(1);
        if (in_sync) begin
          armed_reg  <= 1'b1;
          primed_reg <= 1'b0;
        end else if (phase_b && armed_reg) begin
          primed_reg <= 1'b1;
        end
        if (emit) begin
          out_valid <= 1'b1;
          out_sync  <= phase_b && (cnt_eff == CW'(D));
          out_re    <= res_re;
          out_im    <= res_im;
        end
      end
    end
  end

endmodule
